spi_sd_cmd_receiver: RTL and testbench
======================================

Name: spi_sd_cmd_receiver

Overview:
SPI-slave front end for an SD-card emulator. It receives SD command frames on SPI_DI and presents the 6-bit command index and the 32-bit argument, with progress and success flags, in the system clock domain. It sits between the SPI pins and the card command-handling logic. An optional debug unit latches sticky flags for recognised commands, intended to drive LEDs.

Parameters:
None (all widths fixed).

Ports:
- clock  in  1  system clock; must be at least 2x SPI_CLK frequency.
- reset  in  1  asynchronous, active-high reset.
- io_SPI_CLK  in  1  SPI clock from host; mode 0; sampled in the clock domain.
- io_SPI_CS  in  1  chip select, active low.
- io_SPI_DI  in  1  host-to-card data.
- io_SPI_DO  out  1  card-to-host data.
- io_DO  in  1  response bit from downstream logic.
- io_DI  out  1  io_SPI_DI forwarded to downstream logic.
- io_CommandReadFinished  out  1  all 6 command bits received.
- io_ArgumentReadFinished  out  1  all 32 argument bits received.
- io_ReadSuccess  out  1  complete frame received with a valid end bit.
- io_Command  out  6  received command index.
- io_CommandArgument  out  32  received argument.
- io____state  out  3  FSM state (debug).
- io____counter  out  3  bit counter (debug).
- io____buffer  out  8  shift register of the last 8 sampled bits (debug).
- io_CMD0, io_CMD8, io_ACMD41, io_CMD16  out  1 each  sticky command-seen flags (optional feature).

Behaviour:
- Reset values: all outputs 0, except io_SPI_DO, which follows its normal rule. FSM state = IDLE (0), counter = 0, buffer = 0.
- SPI_CLK edge detection:
  - Register SPI_CLK each clock.
  - A rising edge is spi_clk && !spi_clk_q.
  - io_SPI_DI is sampled on the clock cycle in which the rising edge is detected.
  - No other clock cycle changes state.
- On every sampled bit: buffer <= {buffer[6:0], DI}.
- Frame format, 47 sampled bits, each field LSB first:
  - start bit 0;
  - transmission bit 1;
  - Command[0..5];
  - Argument[0..31];
  - 6 CRC bits (ignored);
  - end bit, which must be 1.
- FSM states and transitions (encoding in parentheses):
  - IDLE (0): a sampled DI=0 moves to TX and clears all three flags.
  - TX (1): DI=1 moves to CMD with counter=0; DI=0 returns to IDLE.
  - CMD (2): Command[counter] <= DI. At counter==5, set CommandReadFinished, go to ARG, counter=0, byte index=0.
  - ARG (3): CommandArgument[8*byte+counter] <= DI. Counter wraps 7->0 and increments the 2-bit byte index. After byte 3 bit 7, set ArgumentReadFinished and go to CRC with counter=0.
  - CRC (4): count 7 bits. On the 7th bit (counter==6), ReadSuccess <= DI, then go to IDLE.
- Flag and data persistence:
  - Flags are levels held until the next start bit.
  - Command and CommandArgument hold their values until overwritten.
- io_SPI_CS high: the FSM is forced to IDLE at the next clock, flags are held, and io_SPI_DO = 1.
- io_SPI_CS low: io_SPI_DO = io_DO.
- io_DI = io_SPI_DI (combinational).
- Idle line high (DI=1) keeps the FSM in IDLE indefinitely.
- Reset asserted mid-frame aborts immediately to the reset values.

Optional Feature:
Macro SPI_RX_LED_DEBUG_EN.
- Defined: a debug unit watches the rising edge of io_ReadSuccess (registered compare) and acts on Command:
  - 0 sets CMD0;
  - 8 sets CMD8;
  - 16 sets CMD16;
  - 55 sets an internal app_pending flag;
  - 41 with app_pending set sets ACMD41.
- Defined: any successful frame other than 55 clears app_pending; a repeated 55 keeps it set.
- Defined: the four flags are sticky until reset.
- Not defined: the four outputs are tied 0 and no debug logic is built.

Test Plan:
- Reset plus 8 idle SPI clocks with DI=1 -> state 0, all flags 0, Command=0, CommandArgument=0.
- Frame with Command=0, Arg=1218 (0x000004C2), end bit 1:
  - -> CommandReadFinished after bit 8;
  - -> ArgumentReadFinished after bit 40;
  - -> ReadSuccess=1, Command=0, CommandArgument=0x000004C2;
  - -> CMD0=1 (with macro).
- Frame with Command=8, then Command=16 -> Command reads 8, then 16; CMD8 and CMD16 set.
- Two consecutive Command=55 frames, then Command=16 -> ACMD41 stays 0.
- Command=55 immediately followed by Command=41 -> ACMD41=1.
- Frame with end bit 0, or with the transmission bit 0 -> ReadSuccess=0 and the FSM returns to IDLE. Separately, CS raised mid-frame -> state 0 and SPI_DO=1.

Source files
------------

// File: rtl/spi_sd_cmd_receiver.sv
// SPI-slave receiver for SD command frames: decodes the 6-bit index and 32-bit argument
// in the system clock domain. Optional sticky LED flags behind SPI_RX_LED_DEBUG_EN.
module spi_sd_cmd_receiver (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_SPI_CLK,
    input  logic        io_SPI_CS,
    input  logic        io_SPI_DI,
    output logic        io_SPI_DO,
    input  logic        io_DO,
    output logic        io_DI,
    output logic        io_CommandReadFinished,
    output logic        io_ArgumentReadFinished,
    output logic        io_ReadSuccess,
    output logic [5:0]  io_Command,
    output logic [31:0] io_CommandArgument,
    output logic [2:0]  io____state,
    output logic [2:0]  io____counter,
    output logic [7:0]  io____buffer,
    output logic        io_CMD0,
    output logic        io_CMD8,
    output logic        io_ACMD41,
    output logic        io_CMD16
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX   = 3'd1,
        S_CMD  = 3'd2,
        S_ARG  = 3'd3,
        S_CRC  = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [1:0]  r_byte, w_byte_nxt;
    logic [7:0]  r_buf, w_buf_nxt;
    logic [5:0]  r_cmd, w_cmd_nxt;
    logic [31:0] r_arg, w_arg_nxt;
    logic        r_crf, w_crf_nxt;
    logic        r_arf, w_arf_nxt;
    logic        r_rs, w_rs_nxt;
    logic        r_spi_clk_q;
    logic        w_sample;

    // A bit is taken only on a detected SPI_CLK rising edge while selected.
    assign w_sample = io_SPI_CLK & ~r_spi_clk_q & ~io_SPI_CS;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_spi_clk_q <= 1'b0;
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_byte      <= 2'd0;
            r_buf       <= 8'd0;
            r_cmd       <= 6'd0;
            r_arg       <= 32'd0;
            r_crf       <= 1'b0;
            r_arf       <= 1'b0;
            r_rs        <= 1'b0;
        end else begin
            r_spi_clk_q <= io_SPI_CLK;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_byte      <= w_byte_nxt;
            r_buf       <= w_buf_nxt;
            r_cmd       <= w_cmd_nxt;
            r_arg       <= w_arg_nxt;
            r_crf       <= w_crf_nxt;
            r_arf       <= w_arf_nxt;
            r_rs        <= w_rs_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_byte_nxt  = r_byte;
        w_buf_nxt   = r_buf;
        w_cmd_nxt   = r_cmd;
        w_arg_nxt   = r_arg;
        w_crf_nxt   = r_crf;
        w_arf_nxt   = r_arf;
        w_rs_nxt    = r_rs;
        if (io_SPI_CS) begin
            // Deselect aborts any frame but leaves the status flags visible.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
            w_byte_nxt  = 2'd0;
        end else if (w_sample) begin
            w_buf_nxt = {r_buf[6:0], io_SPI_DI};
            case (r_state)
                S_IDLE: begin
                    if (!io_SPI_DI) begin
                        w_state_nxt = S_TX;
                        w_crf_nxt   = 1'b0;
                        w_arf_nxt   = 1'b0;
                        w_rs_nxt    = 1'b0;
                    end
                end
                S_TX: begin
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = io_SPI_DI ? S_CMD : S_IDLE;
                end
                S_CMD: begin
                    w_cmd_nxt[r_cnt] = io_SPI_DI;
                    if (r_cnt == 3'd5) begin
                        w_crf_nxt   = 1'b1;
                        w_state_nxt = S_ARG;
                        w_cnt_nxt   = 3'd0;
                        w_byte_nxt  = 2'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
                S_ARG: begin
                    w_arg_nxt[{r_byte, r_cnt}] = io_SPI_DI;
                    w_cnt_nxt = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_byte_nxt = r_byte + 2'd1;
                        if (r_byte == 2'd3) begin
                            w_arf_nxt   = 1'b1;
                            w_state_nxt = S_CRC;
                            w_cnt_nxt   = 3'd0;
                        end
                    end
                end
                S_CRC: begin
                    // Six CRC bits are skipped; the seventh bit is the end bit.
                    if (r_cnt == 3'd6) begin
                        w_rs_nxt    = io_SPI_DI;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    assign io_SPI_DO               = io_SPI_CS ? 1'b1 : io_DO;
    assign io_DI                   = io_SPI_DI;
    assign io_CommandReadFinished  = r_crf;
    assign io_ArgumentReadFinished = r_arf;
    assign io_ReadSuccess          = r_rs;
    assign io_Command              = r_cmd;
    assign io_CommandArgument      = r_arg;
    assign io____state             = r_state;
    assign io____counter           = r_cnt;
    assign io____buffer            = r_buf;

`ifdef SPI_RX_LED_DEBUG_EN
    logic r_rs_q, r_app, r_cmd0, r_cmd8, r_cmd16, r_acmd41;
    logic w_rs_rise;

    assign w_rs_rise = r_rs & ~r_rs_q;

    // Sticky per-command flags; 55 arms the ACMD prefix for exactly the next good frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rs_q   <= 1'b0;
            r_app    <= 1'b0;
            r_cmd0   <= 1'b0;
            r_cmd8   <= 1'b0;
            r_cmd16  <= 1'b0;
            r_acmd41 <= 1'b0;
        end else begin
            r_rs_q <= r_rs;
            if (w_rs_rise) begin
                case (r_cmd)
                    6'd0:    r_cmd0  <= 1'b1;
                    6'd8:    r_cmd8  <= 1'b1;
                    6'd16:   r_cmd16 <= 1'b1;
                    6'd41:   if (r_app) r_acmd41 <= 1'b1;
                    default: ;
                endcase
                r_app <= (r_cmd == 6'd55);
            end
        end
    end

    assign io_CMD0   = r_cmd0;
    assign io_CMD8   = r_cmd8;
    assign io_CMD16  = r_cmd16;
    assign io_ACMD41 = r_acmd41;
`else
    assign io_CMD0   = 1'b0;
    assign io_CMD8   = 1'b0;
    assign io_CMD16  = 1'b0;
    assign io_ACMD41 = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sd_cmd_receiver.sv
// Directed + randomized bench for spi_sd_cmd_receiver; expectations come from a frame-level
// model of the SD command format and the LED flag rules (SPI_RX_LED_DEBUG_EN aware).
module tb_spi_sd_cmd_receiver;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_SPI_CLK, io_SPI_CS, io_SPI_DI, io_DO;
    logic        io_SPI_DO, io_DI;
    logic        io_CommandReadFinished, io_ArgumentReadFinished, io_ReadSuccess;
    logic [5:0]  io_Command;
    logic [31:0] io_CommandArgument;
    logic [2:0]  io____state, io____counter;
    logic [7:0]  io____buffer;
    logic        io_CMD0, io_CMD8, io_ACMD41, io_CMD16;

    int checks = 0;
    int errors = 0;

`ifdef SPI_RX_LED_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    // Frame-level model of the LED flags.
    bit m_cmd0, m_cmd8, m_cmd16, m_acmd41, m_app;

    spi_sd_cmd_receiver dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_SPI_CLK             (io_SPI_CLK),
        .io_SPI_CS              (io_SPI_CS),
        .io_SPI_DI              (io_SPI_DI),
        .io_SPI_DO              (io_SPI_DO),
        .io_DO                  (io_DO),
        .io_DI                  (io_DI),
        .io_CommandReadFinished (io_CommandReadFinished),
        .io_ArgumentReadFinished(io_ArgumentReadFinished),
        .io_ReadSuccess         (io_ReadSuccess),
        .io_Command             (io_Command),
        .io_CommandArgument     (io_CommandArgument),
        .io____state            (io____state),
        .io____counter          (io____counter),
        .io____buffer           (io____buffer),
        .io_CMD0                (io_CMD0),
        .io_CMD8                (io_CMD8),
        .io_ACMD41              (io_ACMD41),
        .io_CMD16               (io_CMD16)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SPI mode-0 bit: data set up while SPI_CLK is low, sampled on its rise.
    task automatic spi_bit(input logic b);
        io_SPI_DI = b;
        repeat (2) @(negedge clock);
        io_SPI_CLK = 1'b1;
        repeat (2) @(negedge clock);
        io_SPI_CLK = 1'b0;
    endtask

    task automatic model_frame(input logic [5:0] cmd);
        if (cmd == 6'd0)  m_cmd0  = 1'b1;
        if (cmd == 6'd8)  m_cmd8  = 1'b1;
        if (cmd == 6'd16) m_cmd16 = 1'b1;
        if (cmd == 6'd41 && m_app) m_acmd41 = 1'b1;
        m_app = (cmd == 6'd55);
    endtask

    task automatic check_leds(input string tag);
        check({tag, "_cmd0"},   32'(io_CMD0),   32'(DBG & m_cmd0));
        check({tag, "_cmd8"},   32'(io_CMD8),   32'(DBG & m_cmd8));
        check({tag, "_cmd16"},  32'(io_CMD16),  32'(DBG & m_cmd16));
        check({tag, "_acmd41"}, 32'(io_ACMD41), 32'(DBG & m_acmd41));
    endtask

    // Send a full 47-bit frame LSB-first per field, with random CRC, then two idle bits.
    task automatic send_frame(input logic [5:0] cmd, input logic [31:0] arg, input logic endb);
        logic [46:0] f;
        logic [7:0]  exp_buf;
        logic [5:0]  crc;
        crc = 6'($urandom);
        f = {endb, crc, arg, cmd, 1'b1, 1'b0};
        for (int k = 0; k < 47; k++) begin
            spi_bit(f[k]);
            if (k == 6)  check("crf_before", 32'(io_CommandReadFinished), 32'd0);
            if (k == 7)  check("crf_after",  32'(io_CommandReadFinished), 32'd1);
            if (k == 38) check("arf_before", 32'(io_ArgumentReadFinished), 32'd0);
            if (k == 39) check("arf_after",  32'(io_ArgumentReadFinished), 32'd1);
        end
        for (int j = 0; j < 8; j++) exp_buf[j] = f[46-j];
        check("frame_state",   32'(io____state),   32'd0);
        check("frame_counter", 32'(io____counter), 32'd0);
        check("frame_rs",      32'(io_ReadSuccess), 32'(endb));
        check("frame_cmd",     32'(io_Command),     32'(cmd));
        check("frame_arg",     io_CommandArgument,  arg);
        check("frame_buf",     32'(io____buffer),   32'(exp_buf));
        if (endb) model_frame(cmd);
        spi_bit(1'b1);
        spi_bit(1'b1);
        check_leds("frame");
    endtask

    initial begin
        reset      = 1'b1;
        io_SPI_CLK = 1'b0;
        io_SPI_CS  = 1'b0;
        io_SPI_DI  = 1'b1;
        io_DO      = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_state", 32'(io____state),   32'd0);
        check("rst_cnt",   32'(io____counter), 32'd0);
        check("rst_buf",   32'(io____buffer),  32'd0);
        check("rst_rs",    32'(io_ReadSuccess), 32'd0);
        reset = 1'b0;

        // Idle line high: FSM stays idle, buffer fills with ones.
        for (int i = 0; i < 8; i++) spi_bit(1'b1);
        check("idle_state", 32'(io____state), 32'd0);
        check("idle_buf",   32'(io____buffer), 32'hFF);
        check("idle_crf",   32'(io_CommandReadFinished), 32'd0);
        check("idle_arf",   32'(io_ArgumentReadFinished), 32'd0);
        check("idle_cmd",   32'(io_Command), 32'd0);
        check("idle_arg",   io_CommandArgument, 32'd0);
        check_leds("idle");

        send_frame(6'd0, 32'h0000_04C2, 1'b1);
        send_frame(6'd8, 32'h0000_01AA, 1'b1);
        send_frame(6'd16, 32'h0000_0200, 1'b1);
        // 55,55,16: the prefix is consumed by 16, so ACMD41 must not appear.
        send_frame(6'd55, 32'h0, 1'b1);
        send_frame(6'd55, 32'h0, 1'b1);
        send_frame(6'd16, 32'h0000_0200, 1'b1);
        check("no_acmd41", 32'(io_ACMD41), 32'd0);
        send_frame(6'd55, 32'h0, 1'b1);
        send_frame(6'd41, 32'h4000_0000, 1'b1);

        for (int i = 0; i < 4; i++) send_frame(6'($urandom), $urandom, 1'b1);

        // Transmission bit 0 aborts the frame and clears the flags.
        spi_bit(1'b0);
        spi_bit(1'b0);
        check("tx0_state", 32'(io____state), 32'd0);
        check("tx0_rs",    32'(io_ReadSuccess), 32'd0);
        spi_bit(1'b1);
        spi_bit(1'b1);
        check("tx0_idle", 32'(io____state), 32'd0);

        send_frame(6'($urandom), $urandom, 1'b0);
        check_leds("endbit0");

        // Deselect mid-frame: back to idle, flags held, SPI_DO driven high.
        io_DO = 1'b1;
        @(negedge clock);
        check("do_follow1", 32'(io_SPI_DO), 32'd1);
        io_DO = 1'b0;
        @(negedge clock);
        check("do_follow0", 32'(io_SPI_DO), 32'd0);
        spi_bit(1'b0);
        spi_bit(1'b1);
        for (int i = 0; i < 8; i++) spi_bit(1'(i % 2));
        check("cs_pre_state", 32'(io____state), 32'd3);
        io_SPI_CS = 1'b1;
        repeat (2) @(negedge clock);
        check("cs_state", 32'(io____state), 32'd0);
        check("cs_do",    32'(io_SPI_DO),   32'd1);
        check("cs_crf",   32'(io_CommandReadFinished), 32'd1);
        io_SPI_CS = 1'b0;
        spi_bit(1'b1);
        check("cs_after", 32'(io____state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
